pipeline_hazard: RTL and testbench

Hazard and sequencing controller for the five-stage MIPS pipeline. It drives the EX-stage operand forwarding selects and the stall and flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers. It also owns the occupancy FSM for the iterative multiply/divide unit, which holds the EX stage for `MDLAT` cycles. It sits beside the stage modules in the pipeline top level and holds no datapath state of its own.

---
 rtl/pipeline_hazard.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard.sv
// Hazard controller for the five-stage pipeline: operand forwarding, load-use and
// redirect stall/flush control, and occupancy sequencing for the iterative mult/div unit.
//
// state | meaning
// IDLE  | no mult/div in flight; md_start_e launches one
// BUSY  | mult/div occupying EX, cnt counts down the remaining latency
// DONE  | result valid this cycle, EX released
module pipeline_hazard #(
  parameter int MDLAT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       pcsrc_e,
  input  logic       md_start_e,
  output logic [1:0] fwda_e,
  output logic [1:0] fwdb_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       md_go,
  output logic       md_busy,
  output logic       md_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       lwstall, mdstall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (regwrite_m && (writereg_m != 5'd0) && (writereg_m == src))
      return 2'b10;
    else if (regwrite_w && (writereg_w != 5'd0) && (writereg_w == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (md_start_e) begin
          state_nxt = S_BUSY;
          cnt_nxt   = 8'(MDLAT - 1);
        end
      end
      S_BUSY: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign lwstall = memtoreg_e && regwrite_e && (writereg_e != 5'd0) &&
                   ((writereg_e == rs_d) || (writereg_e == rt_d));
  assign mdstall = (state == S_BUSY) || ((state == S_IDLE) && md_start_e);

  // Priority: reset > mdstall > redirect > load-use.
  always_comb begin
    fwda_e  = 2'b00;
    fwdb_e  = 2'b00;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    md_go   = 1'b0;
    md_busy = 1'b0;
    md_done = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      fwda_e  = fwd_sel(rs_e);
      fwdb_e  = fwd_sel(rt_e);
      md_go   = (state == S_IDLE) && md_start_e;
      md_busy = mdstall;
      md_done = (state == S_DONE);
      if (mdstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lwstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard.sv
// Bench for pipeline_hazard (MDLAT=4): directed vector table, hand-written mult/div
// sequences, then randomized cycles checked against a cycle-count reference model.
module tb_pipeline_hazard;
  localparam int MDLAT = 4;

  // {fwda, fwdb, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_go, md_busy, md_done}
  localparam logic [12:0] EXP_RST  = 13'b00_00_000_111_000;
  localparam logic [12:0] EXP_GO   = 13'b00_00_111_001_110;
  localparam logic [12:0] EXP_BUSY = 13'b00_00_111_001_010;
  localparam logic [12:0] EXP_DONE = 13'b00_00_000_000_001;
  localparam logic [12:0] EXP_NONE = 13'b00_00_000_000_000;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic regwrite_e, regwrite_m, regwrite_w, memtoreg_e, pcsrc_e, md_start_e;
  logic [1:0] fwda_e, fwdb_e;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_go, md_busy, md_done;
  logic [12:0] act;

  int n_pass = 0;
  int n_total = 0;
  int phase = 0;  // 0 = no mult/div; k = k-th cycle after the start pulse

  always #5 clk = ~clk;

  pipeline_hazard #(.MDLAT(MDLAT)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .pcsrc_e(pcsrc_e), .md_start_e(md_start_e),
    .fwda_e(fwda_e), .fwdb_e(fwdb_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .md_go(md_go), .md_busy(md_busy), .md_done(md_done)
  );

  assign act = {fwda_e, fwdb_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
                md_go, md_busy, md_done};

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic rw_e, rw_m, rw_w, mtr, pc;
    logic [12:0] exp;
    string name;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (regwrite_m && writereg_m != 0 && writereg_m == src) return 2'b10;
    if (regwrite_w && writereg_w != 0 && writereg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] model_exp();
    logic lw, md, done, go;
    logic [12:0] e;
    if (reset) return EXP_RST;
    lw   = memtoreg_e && regwrite_e && writereg_e != 0 &&
           (writereg_e == rs_d || writereg_e == rt_d);
    go   = (phase == 0) && md_start_e;
    md   = go || (phase >= 1 && phase <= MDLAT - 1);
    done = (phase == MDLAT);
    e = {ref_fwd(rs_e), ref_fwd(rt_e), 9'b0};
    if (md)           e[8:3] = 6'b111_001;
    else if (pcsrc_e) e[8:3] = 6'b000_110;
    else if (lw)      e[8:3] = 6'b110_010;
    e[2:0] = {go, md, done};
    return e;
  endfunction

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
    {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, pcsrc_e, md_start_e} = '0;
  endtask

  // Compare mid-cycle, then advance one clock and step the reference model.
  task automatic check(input string name, input logic [12:0] exp);
    #2;
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, act, exp);
    @(posedge clk);
    if (reset) phase = 0;
    else if (phase == 0) phase = md_start_e ? 1 : 0;
    else if (phase == MDLAT) phase = 0;
    else phase = phase + 1;
    #1;
  endtask

  initial begin
    //            rs_d rt_d rs_e rt_e wr_e wr_m wr_w rwe rwm rww mtr pc  exp
    vecs[0] = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 13'b10_00_000_000_000, "fwd_mem_prio"};
    vecs[1] = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0, 13'b01_00_000_000_000, "fwd_wb"};
    vecs[2] = '{0, 0, 0, 5, 0, 0, 5, 0, 1, 1, 0, 0, 13'b00_01_000_000_000, "fwd_r0"};
    vecs[3] = '{0, 0, 3, 7, 0, 7, 7, 0, 1, 1, 0, 0, 13'b00_10_000_000_000, "fwdb_mem"};
    vecs[4] = '{0, 8, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 13'b00_00_110_010_000, "loaduse_rt"};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, EXP_NONE, "loaduse_r0"};
    vecs[6] = '{8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0, 0, EXP_NONE, "no_load"};
    vecs[7] = '{0, 8, 0, 0, 8, 0, 0, 1, 0, 0, 1, 1, 13'b00_00_000_110_000, "redirect_over_lw"};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b00_00_000_110_000, "redirect"};
    vecs[9] = '{9, 0, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0, EXP_NONE, "load_no_rw"};

    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset", EXP_RST);
    reset = 1'b0;

    foreach (vecs[i]) begin
      rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d; rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
      writereg_e = vecs[i].wr_e; writereg_m = vecs[i].wr_m; writereg_w = vecs[i].wr_w;
      regwrite_e = vecs[i].rw_e; regwrite_m = vecs[i].rw_m; regwrite_w = vecs[i].rw_w;
      memtoreg_e = vecs[i].mtr; pcsrc_e = vecs[i].pc; md_start_e = 1'b0;
      check(vecs[i].name, vecs[i].exp);
    end

    // Mult/div with md_start_e held: go, 3 busy, done, then a fresh go.
    clear_inputs();
    md_start_e = 1'b1;
    check("md_c0_go", EXP_GO);
    for (int c = 1; c < MDLAT; c++) check("md_busy", EXP_BUSY);
    check("md_c4_done", EXP_DONE);
    check("md_c5_rego", EXP_GO);

    // Redirect and load-use are ignored while busy.
    pcsrc_e = 1'b1; memtoreg_e = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd8; rt_d = 5'd8;
    check("md_dominance", EXP_BUSY);

    // Reset at cnt=2 with a forwarding match present.
    clear_inputs();
    md_start_e = 1'b1; reset = 1'b1; rs_e = 5'd5; writereg_m = 5'd5; regwrite_m = 1'b1;
    check("reset_mid_busy", EXP_RST);
    clear_inputs();
    reset = 1'b0;
    check("post_reset_idle", EXP_NONE);
    md_start_e = 1'b1;
    check("post_reset_go", EXP_GO);
    md_start_e = 1'b0;
    check("post_reset_busy", EXP_BUSY);

    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      rs_d       = 5'($urandom_range(0, 3));
      rt_d       = 5'($urandom_range(0, 3));
      rs_e       = 5'($urandom_range(0, 3));
      rt_e       = 5'($urandom_range(0, 3));
      writereg_e = 5'($urandom_range(0, 3));
      writereg_m = 5'($urandom_range(0, 3));
      writereg_w = 5'($urandom_range(0, 3));
      regwrite_e = 1'($urandom_range(0, 1));
      regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1));
      memtoreg_e = ($urandom_range(0, 2) == 0);
      pcsrc_e    = ($urandom_range(0, 4) == 0);
      md_start_e = ($urandom_range(0, 5) == 0);
      check("random", model_exp());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
